cache_mem_arbiter: RTL and testbench

- Arbitrates the single physical-memory burst port between the instruction cache (fetch-side misses) and the data cache (MEM-stage misses and write-backs).
- Sits between the two L1 caches and the memory/L2 interface.
- Serialises requests with fair round-robin selection on contention.
- Holds each grant until the memory responds, so a long D-cache write-back cannot be interrupted by the fetch stage.

---
 rtl/cache_mem_arbiter.sv | 104 ++++++++++
 tb/tb_cache_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shares one memory burst port between the I-cache and the D-cache.
// Round-robin on ties; a grant is held until the memory completes.
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // Memory side
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp,
  // Debug: exposes the FSM state directly
  output logic [1:0]        grant
);

  // Handshake: each cache holds its request high until its one-cycle resp
  // pulse; the memory holds m_read/m_write until its one-cycle m_resp pulse.

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } state_e;

  state_e state_q;
  logic   last_owner_q;  // 0 = I-cache served last, 1 = D-cache served last

  logic i_req;
  logic d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // On a tie the cache that was not served last wins.
          if (i_req && (!d_req || last_owner_q)) begin
            state_q      <= SERVE_I;
            last_owner_q <= 1'b0;
          end else if (d_req) begin
            state_q      <= SERVE_D;
            last_owner_q <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (m_resp) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = state_q;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // Memory-side outputs depend on the registered state, never on m_resp.
  always_comb begin
    m_read    = 1'b0;
    m_write   = 1'b0;
    m_address = '0;
    m_wdata   = '0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state_q)
      SERVE_I: begin
        m_read    = 1'b1;
        m_address = i_address;
        i_resp    = m_resp;
      end
      SERVE_D: begin
        // A pending write-back goes out before the fill.
        m_read    = d_read & ~d_write;
        m_write   = d_write;
        m_address = d_address;
        m_wdata   = d_wdata;
        d_resp    = m_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios followed by randomized
// traffic, checked cycle by cycle against a behavioural arbiter model.
module tb_cache_mem_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT ----------------
  logic              i_read, d_read, d_write, m_resp;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] d_wdata, m_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, m_wdata;
  logic              i_resp, d_resp, m_read, m_write;
  logic [ADDR_W-1:0] m_address;
  logic [1:0]        grant;

  cache_mem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .m_read(m_read), .m_write(m_write), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp), .grant(grant)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];    // expected owner order at each new grant
  logic [1:0] prev_grant = 2'b00;

  // Behavioural model: who holds the port (0 none, 1 I, 2 D) and who went last.
  int model_owner;
  bit model_last_d;
  bit exp_iresp, exp_dresp;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // Compare one cycle (inputs already settled after the falling edge), then
  // advance the model across the next rising edge.
  task automatic step();
    logic [1:0]        e_grant;
    logic              e_rd, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata;
    #1;
    e_grant   = (model_owner == 1) ? 2'b01 : (model_owner == 2) ? 2'b10 : 2'b00;
    e_rd      = (model_owner == 1) || (model_owner == 2 && d_read && !d_write);
    e_wr      = (model_owner == 2) && d_write;
    e_addr    = (model_owner == 1) ? i_address : (model_owner == 2) ? d_address : '0;
    e_wdata   = (model_owner == 2) ? d_wdata : '0;
    exp_iresp = (model_owner == 1) && m_resp;
    exp_dresp = (model_owner == 2) && m_resp;

    check("grant",     LINE_W'(grant),     LINE_W'(e_grant));
    check("m_read",    LINE_W'(m_read),    LINE_W'(e_rd));
    check("m_write",   LINE_W'(m_write),   LINE_W'(e_wr));
    check("m_address", LINE_W'(m_address), LINE_W'(e_addr));
    check("m_wdata",   m_wdata,            e_wdata);
    check("i_resp",    LINE_W'(i_resp),    LINE_W'(exp_iresp));
    check("d_resp",    LINE_W'(d_resp),    LINE_W'(exp_dresp));
    if (exp_iresp) check("i_rdata", i_rdata, m_rdata);
    if (exp_dresp) check("d_rdata", d_rdata, m_rdata);
    if (grant != 2'b00 && prev_grant == 2'b00 && exp_q.size() > 0)
      check("grant_order", LINE_W'(grant), LINE_W'(exp_q.pop_front()));
    prev_grant = grant;

    @(posedge clk);
    if (rst) begin
      model_owner  = 0;
      model_last_d = 1'b1;
    end else if (model_owner != 0) begin
      if (m_resp) model_owner = 0;
    end else begin
      if (i_read && (d_read || d_write)) model_owner = model_last_d ? 1 : 2;
      else if (i_read)                   model_owner = 1;
      else if (d_read || d_write)        model_owner = 2;
      if (model_owner != 0) model_last_d = (model_owner == 2);
    end
    @(negedge clk);
  endtask

  // Memory waits `lat` cycles, then completes with `data`.
  task automatic serve(input int lat, input logic [LINE_W-1:0] data);
    m_resp = 1'b0;
    for (int k = 0; k < lat; k++) step();
    m_resp  = 1'b1;
    m_rdata = data;
    step();
    m_resp  = 1'b0;
  endtask

  // ---------------- random driver state ----------------
  bit i_pend, d_rd_pend, d_wr_pend;

  initial begin
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; m_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; m_rdata = '0;
    model_owner = 0; model_last_d = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    step();

    // Contention straight after reset: I first, then alternate.
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    i_read = 1; i_address = 32'h0000_2000;
    d_read = 1; d_address = 32'h0000_3000;
    step();
    for (int t = 0; t < 4; t++) begin
      serve(2, rnd_line());
      step();
    end
    check("order_drained", LINE_W'(exp_q.size()), LINE_W'(0));
    i_read = 0; d_read = 0;
    step(); step();

    // I-only miss, response six cycles after the request.
    i_read = 1; i_address = 32'h4000_0040;
    step();
    serve(5, {32{8'hA5}});
    i_read = 0;
    step();

    // D write-back then fill on the same line.
    d_read = 1; d_write = 1; d_address = 32'h0000_1000;
    d_wdata = {8{32'h1234_5678}};
    step();
    serve(2, '0);
    d_write = 0;
    step();
    serve(1, rnd_line());
    d_read = 0;
    step();

    // Late I arrival while D owns the port.
    d_read = 1; d_address = 32'h0000_5000;
    step(); step();
    i_read = 1; i_address = 32'h0000_6000;
    serve(3, rnd_line());
    d_read = 0;
    step();
    serve(1, rnd_line());
    i_read = 0;
    step();

    // Reset in the middle of an I transaction, then a stray m_resp.
    i_read = 1; i_address = 32'h0000_7000;
    step(); step();
    rst = 1;
    step();
    rst = 0; i_read = 0;
    step();
    m_resp = 1; m_rdata = rnd_line();
    step();
    m_resp = 0;
    step();

    // Randomized traffic
    i_pend = 0; d_rd_pend = 0; d_wr_pend = 0;
    for (int c = 0; c < 2000; c++) begin
      if (!i_pend && $urandom_range(0, 3) == 0) begin
        i_pend    = 1;
        i_address = $urandom() & 32'hFFFF_FFE0;
      end
      if (!d_rd_pend && !d_wr_pend && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       d_rd_pend = 1;
          1:       d_wr_pend = 1;
          default: begin d_rd_pend = 1; d_wr_pend = 1; end
        endcase
        d_address = $urandom() & 32'hFFFF_FFE0;
        d_wdata   = rnd_line();
      end
      i_read  = i_pend;
      d_read  = d_rd_pend;
      d_write = d_wr_pend;
      m_resp  = (model_owner != 0) ? ($urandom_range(0, 2) == 0)
                                   : ($urandom_range(0, 9) == 0);
      m_rdata = rnd_line();
      rst     = ($urandom_range(0, 99) == 0);
      step();
      if (exp_iresp) i_pend = 0;
      if (exp_dresp) begin
        if (d_wr_pend && d_rd_pend) d_wr_pend = 0;
        else begin d_rd_pend = 0; d_wr_pend = 0; end
      end
      if (rst) begin i_pend = 0; d_rd_pend = 0; d_wr_pend = 0; end
    end
    rst = 0; m_resp = 0; i_read = 0; d_read = 0; d_write = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
